// File: rtl/cv32e40p_alu_ft_reconfig_ctrl.sv
// Reconfiguration controller for the fault-tolerant quad-ALU execute stage (ALU3 = spare).
// Optional spare warm-up phase is compiled in with `define CV32E40P_FT_SPARE_WARMUP_EN.
module cv32e40p_alu_ft_reconfig_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] faulty_i,
  input  logic       ex_ready_i,
  output logic [2:0] sel_mux_o,
  output logic [3:0] clock_en_o,
  output logic [3:0] retired_o,
  output logic       reconfig_busy_o,
  output logic       reconfig_done_o,
  output logic       degraded_o,
  output logic       fatal_o
);

  typedef enum logic [1:0] {StIdle, StWarmup, StWaitIdle} state_e;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_settle_check
    $error("SETTLE_CYCLES must be in 1..15");
  end

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] clk_en_q, clk_en_d;
  logic [3:0] retired_q, retired_d;
  logic [1:0] target_q, target_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       degraded_q, degraded_d;
  logic       fatal_q, fatal_d;
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`endif

  logic [3:0] voting, rel, excl, counted, tgt_mask, low_mask;
  logic [2:0] n_faulty;
  logic [1:0] lowest;
  logic       spare_avail, spare_fault, start_swap, pending, commit, abort;

  // ALU3 votes as soon as any mux bit routes the spare in.
  always_comb begin
    voting      = {~&sel_q, sel_q};
    rel         = faulty_i & voting;
    spare_avail = &sel_q & ~retired_q[3];
    spare_fault = spare_avail & faulty_i[3];
    lowest      = rel[0] ? 2'd0 : (rel[1] ? 2'd1 : 2'd2);
    pending     = (state_q != StIdle);
    start_swap  = (state_q == StIdle) & spare_avail & ~faulty_i[3] & (|rel[2:0]);
    tgt_mask    = 4'b0001 << target_q;
    low_mask    = 4'b0001 << lowest;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    clk_en_d  = clk_en_q;
    retired_d = retired_q;
    target_d  = target_q;
    done_d    = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (spare_fault) begin
          retired_d[3] = 1'b1;
          clk_en_d[3]  = 1'b0;
        end else if (start_swap) begin
          target_d = lowest;
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
          clk_en_d[3] = 1'b1;
          cnt_d       = SettleInit;
          state_d     = StWarmup;
`else
          state_d     = StWaitIdle;
`endif
        end
      end
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
      StWarmup: begin
        if (faulty_i[3]) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = StWaitIdle;
        end
      end
`endif
      StWaitIdle: begin
        if (faulty_i[3]) abort = 1'b1;
        else if (ex_ready_i) commit = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d      = StIdle;
      clk_en_d[3]  = 1'b0;
      retired_d[3] = 1'b1;
    end
    // Mux and clock-gate change on the same edge so the voter never sees an unclocked ALU.
    if (commit) begin
      state_d   = StIdle;
      sel_d     = sel_q & ~tgt_mask[2:0];
      clk_en_d  = (clk_en_q & ~tgt_mask) | 4'b1000;
      retired_d = retired_q | tgt_mask;
      done_d    = 1'b1;
    end
    busy_d = (state_d != StIdle);
  end

  // The ALU being (or about to be) swapped out is not counted against the voter.
  always_comb begin
    excl       = pending ? tgt_mask : (start_swap ? low_mask : 4'b0000);
    counted    = rel & ~excl;
    n_faulty   = 3'(counted[0]) + 3'(counted[1]) + 3'(counted[2]) + 3'(counted[3]);
    fatal_d    = fatal_q | (n_faulty >= 3'd2);
    degraded_d = degraded_q | ((n_faulty == 3'd1) & ~pending & ~start_swap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= 3'b111;
      clk_en_q   <= 4'b0111;
      retired_q  <= 4'b0000;
      target_q   <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      degraded_q <= 1'b0;
      fatal_q    <= 1'b0;
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
      cnt_q      <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      clk_en_q   <= clk_en_d;
      retired_q  <= retired_d;
      target_q   <= target_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      degraded_q <= degraded_d;
      fatal_q    <= fatal_d;
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign sel_mux_o       = sel_q;
  assign clock_en_o      = clk_en_q;
  assign retired_o       = retired_q;
  assign reconfig_busy_o = busy_q;
  assign reconfig_done_o = done_q;
  assign degraded_o      = degraded_q;
  assign fatal_o         = fatal_q;

endmodule

// File: tb/tb_cv32e40p_alu_ft_reconfig_ctrl.sv
// Self-checking bench for cv32e40p_alu_ft_reconfig_ctrl: directed scenarios plus random
// fault/ready traffic compared against a slot-assignment reference model.
module tb_cv32e40p_alu_ft_reconfig_ctrl;
  localparam int unsigned Settle = 2;
`ifdef CV32E40P_FT_SPARE_WARMUP_EN
  localparam bit Warm = 1'b1;
`else
  localparam bit Warm = 1'b0;
`endif
  localparam int SettleEff = Warm ? Settle : 0;
  // {sel, clock_en, retired, busy, done, degraded, fatal}
  localparam logic [14:0] ResetBus = {3'b111, 4'b0111, 4'b0000, 4'b0000};

  logic       clk, rst_n, ex_ready;
  logic [3:0] faulty;
  logic [2:0] sel_mux;
  logic [3:0] clock_en, retired;
  logic       busy, done, degraded, fatal;
  logic [14:0] dut_bus;

  int checks = 0;
  int errors = 0;

  cv32e40p_alu_ft_reconfig_ctrl #(.SETTLE_CYCLES(Settle)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .faulty_i       (faulty),
    .ex_ready_i     (ex_ready),
    .sel_mux_o      (sel_mux),
    .clock_en_o     (clock_en),
    .retired_o      (retired),
    .reconfig_busy_o(busy),
    .reconfig_done_o(done),
    .degraded_o     (degraded),
    .fatal_o        (fatal)
  );

  assign dut_bus = {sel_mux, clock_en, retired, busy, done, degraded, fatal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which ALU drives each voter slot, plus a pending swap with its
  // earliest allowed commit edge.
  int         m_slot[3];
  logic [3:0] m_ret;
  bit         m_pend, m_done, m_deg, m_fat;
  int         m_tgt, m_earliest, cyc;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) m_slot[k] = k;
    m_ret = '0; m_pend = 0; m_done = 0; m_deg = 0; m_fat = 0; m_tgt = 0; m_earliest = 0;
  endfunction

  function automatic void model_step(input logic [3:0] f, input logic r);
    logic [3:0] vmask, rel, excl;
    bit spare_ok, start;
    int low, n;
    vmask = '0;
    for (int k = 0; k < 3; k++) vmask[m_slot[k]] = 1'b1;
    spare_ok = (m_slot[0] == 0) && (m_slot[1] == 1) && (m_slot[2] == 2) && !m_ret[3];
    rel = f & vmask;
    low = -1;
    for (int k = 2; k >= 0; k--) if (rel[k]) low = k;
    start = !m_pend && spare_ok && !f[3] && (low >= 0);
    excl = m_pend ? 4'(1 << m_tgt) : (start ? 4'(1 << low) : 4'b0);
    n = $countones(rel & ~excl);
    if (n >= 2) m_fat = 1;
    if (n == 1 && !m_pend && !start) m_deg = 1;
    m_done = 0;
    if (m_pend) begin
      if (f[3]) begin
        m_pend = 0; m_ret[3] = 1'b1;
      end else if (cyc >= m_earliest && r) begin
        m_slot[m_tgt] = 3; m_ret[m_tgt] = 1'b1; m_pend = 0; m_done = 1;
      end
    end else if (spare_ok && f[3]) begin
      m_ret[3] = 1'b1;
    end else if (start) begin
      m_pend = 1; m_tgt = low; m_earliest = cyc + 1 + SettleEff;
    end
    cyc++;
  endfunction

  function automatic logic [14:0] model_bus();
    logic [2:0] s;
    logic [3:0] ce;
    ce = '0;
    for (int k = 0; k < 3; k++) begin
      s[k] = (m_slot[k] == k);
      ce[m_slot[k]] = 1'b1;
    end
    if (m_pend && Warm) ce[3] = 1'b1;
    return {s, ce, m_ret, m_pend, m_done, m_deg, m_fat};
  endfunction

  task automatic tick(input logic [3:0] f, input logic r);
    faulty = f; ex_ready = r;
    @(posedge clk);
    model_step(f, r);
    #2;
  endtask

  task automatic do_reset();
    faulty = '0; ex_ready = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    model_step(4'b0, 1'b0);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_bus !== ResetBus) begin
      errors++; $display("FAIL reset_values: got %b expected %b", dut_bus, ResetBus);
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b1);
      checks++;
      if (dut_bus !== ResetBus || dut_bus !== model_bus()) begin
        errors++; $display("FAIL idle_hold: got %b expected %b", dut_bus, ResetBus);
      end
    end
  endtask

  task automatic test_basic_swap();
    int first_n, pulses;
    do_reset();
    tick(4'b0001, 1'b1);
    checks++;
    if (clock_en !== (Warm ? 4'b1111 : 4'b0111) || busy !== 1'b1) begin
      errors++; $display("FAIL swap_start: got ce=%b busy=%b expected ce=%b busy=1",
                         clock_en, busy, Warm ? 4'b1111 : 4'b0111);
    end
    first_n = -1; pulses = 0;
    for (int n = 1; n <= 8; n++) begin
      tick(4'b0001, 1'b1);
      if (done === 1'b1) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
      checks++;
      if (dut_bus !== model_bus()) begin
        errors++; $display("FAIL swap_model: got %b expected %b", dut_bus, model_bus());
      end
    end
    checks++;
    if (first_n != SettleEff + 1 || pulses != 1) begin
      errors++; $display("FAIL swap_latency: got lat=%0d pulses=%0d expected lat=%0d pulses=1",
                         first_n, pulses, SettleEff + 1);
    end
    checks++;
    if (sel_mux !== 3'b110 || clock_en !== 4'b1110 || retired !== 4'b0001) begin
      errors++; $display("FAIL swap_final: got sel=%b ce=%b ret=%b expected 110 1110 0001",
                         sel_mux, clock_en, retired);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(4'b0001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001, 1'b0);
      checks++;
      if (busy !== 1'b1 || sel_mux !== 3'b111 || dut_bus !== model_bus()) begin
        errors++; $display("FAIL stall_hold: got %b expected %b", dut_bus, model_bus());
      end
    end
    tick(4'b0001, 1'b1);
    checks++;
    if (done !== 1'b1 || sel_mux !== 3'b110 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_commit: got done=%b sel=%b busy=%b expected 1 110 0",
                         done, sel_mux, busy);
    end
  endtask

  task automatic test_spare_fault();
    do_reset();
    tick(4'b1000, 1'b1);
    checks++;
    if (retired !== 4'b1000 || sel_mux !== 3'b111 || clock_en !== 4'b0111 || busy !== 1'b0) begin
      errors++; $display("FAIL spare_retire: got %b expected %b", dut_bus, model_bus());
    end
    tick(4'b1010, 1'b1);
    checks++;
    if (degraded !== 1'b1 || fatal !== 1'b0 || sel_mux !== 3'b111 || dut_bus !== model_bus()) begin
      errors++; $display("FAIL spare_degraded: got %b expected %b", dut_bus, model_bus());
    end
  endtask

  task automatic test_double_fault();
    do_reset();
    tick(4'b0011, 1'b1);
    checks++;
    if (fatal !== 1'b0 || degraded !== 1'b0) begin
      errors++; $display("FAIL double_start: got deg=%b fatal=%b expected 0 0", degraded, fatal);
    end
    for (int i = 0; i < 6; i++) tick(4'b0011, 1'b1);
    checks++;
    if (sel_mux !== 3'b110 || degraded !== 1'b1 || fatal !== 1'b0) begin
      errors++; $display("FAIL double_degraded: got sel=%b deg=%b fatal=%b expected 110 1 0",
                         sel_mux, degraded, fatal);
    end
    tick(4'b0111, 1'b1);
    tick(4'b0111, 1'b1);
    checks++;
    if (fatal !== 1'b1 || dut_bus !== model_bus()) begin
      errors++; $display("FAIL double_fatal: got %b expected %b", dut_bus, model_bus());
    end
  endtask

  task automatic test_reset_mid_swap();
    do_reset();
    for (int i = 0; i < SettleEff + 3; i++) tick(4'b0001, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midswap_busy: got %b expected 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_bus !== ResetBus) begin
      errors++; $display("FAIL midswap_async_reset: got %b expected %b", dut_bus, ResetBus);
    end
    do_reset();
    tick(4'b0000, 1'b1);
    checks++;
    if (dut_bus !== ResetBus || dut_bus !== model_bus()) begin
      errors++; $display("FAIL midswap_after: got %b expected %b", dut_bus, ResetBus);
    end
  endtask

  task automatic test_random();
    logic [3:0] f;
    logic r;
    for (int ep = 0; ep < 16; ep++) begin
      do_reset();
      f = '0;
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 7) == 0) f[$urandom_range(0, 3)] = 1'b1;
        r = 1'($urandom_range(0, 1));
        tick(f, r);
        checks++;
        if (dut_bus !== model_bus()) begin
          errors++;
          $display("FAIL random ep%0d c%0d: got %b expected %b (faulty=%b)",
                   ep, c, dut_bus, model_bus(), f);
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    rst_n = 1'b0; faulty = '0; ex_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic_swap();
    test_stall();
    test_spare_fault();
    test_double_fault();
    test_reset_mid_swap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_alu_ft_reconfig_ctrl.md
# cv32e40p_alu_ft_reconfig_ctrl

Reconfiguration controller for the fault-tolerant quad-ALU execute stage. It watches the per-ALU permanent-fault flags raised by the ALU error counters and keeps three healthy replicas feeding the voter. It drives the 3-bit voter-input mux select and the 4-bit input-pipe clock-gate enables. When a voting ALU is declared permanently faulty, it warms up the spare, waits for a pipeline-idle cycle, swaps the spare in atomically, and then reports degraded or fatal conditions.

## Interface
- `SETTLE_CYCLES`, 2: cycles the spare is clocked before the swap (1..15). Used only when warm-up is compiled in.
- `clk`  in  1  core clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `faulty_i`  in  4  level flags, one per ALU; bit k = ALU k is permanently faulty. Once set, a flag stays set.
- `ex_ready_i`  in  1  EX stage accepts a new instruction this cycle; a swap commits only when this is high.
- `sel_mux_o`  out  3  bit k=1: voter input k+1 takes ALU k; bit k=0: voter input k+1 takes ALU3 (the spare).
- `clock_en_o`  out  4  input-pipe clock enable per ALU.
- `retired_o`  out  4  ALUs permanently removed from service.
- `reconfig_busy_o`  out  1  high while a swap is pending.
- `reconfig_done_o`  out  1  one-cycle pulse on the commit cycle.
- `degraded_o`  out  1  exactly one voting ALU is faulty and no spare is left (the voter still masks it).
- `fatal_o`  out  1  two or more voting ALUs are faulty (the voter cannot mask).

## Operation
- The voting set V is derived from `sel_mux_o`: ALU k is in V when bit k=1, and ALU3 is in V when any bit is 0. A spare is available when `sel_mux_o`=3'b111 and ALU3 is not retired.
- A relevant fault is one where `faulty_i` & V is nonzero. A fault on a retired ALU is ignored.
- A fault on ALU3 while it is idle as spare:
  - set `retired_o[3]`;
  - the spare becomes unavailable;
  - `clock_en_o[3]` stays 0;
  - no swap takes place.
- States:
  - IDLE → WARMUP when a relevant fault is seen on ALU j∈{0,1,2} and a spare is available. Target j is the lowest faulty index. On entry: latch j, set `clock_en_o[3]`=1, load the warm-up counter with `SETTLE_CYCLES`.
  - WARMUP: the counter decrements each cycle. When it reaches 0 → WAIT_IDLE.
  - WAIT_IDLE: on a cycle with `ex_ready_i`=1, commit the swap and go to IDLE. The commit does the following:
    - `sel_mux_o[j]`=0;
    - `clock_en_o[j]`=0;
    - `retired_o[j]`=1;
    - `reconfig_done_o`=1 for one cycle.
  - IDLE with a relevant fault and no spare: do not swap. Set the `degraded_o`/`fatal_o` flags from the faulty count.
- `degraded_o` and `fatal_o` are registered and sticky until reset. They are evaluated every cycle from the popcount of `faulty_i` & V, excluding the target of a pending swap:
  - popcount ≥2 → `fatal_o`;
  - popcount =1 with no swap pending or possible → `degraded_o`.
- Simultaneous events:
  - Faults on two voting ALUs in the same cycle with a spare available: swap the lowest index. The remaining fault then gives `degraded_o` after commit.
  - ALU3 faults while warming up: abort to IDLE, set `clock_en_o[3]`=0 and `retired_o[3]`=1. The pending target falls to the no-spare rule (`degraded_o`).
- New faults arriving during WARMUP or WAIT_IDLE do not change the target.

## Timing
- Reset values:
  - `sel_mux_o`=3'b111;
  - `clock_en_o`=4'b0111;
  - `retired_o`=0;
  - `reconfig_busy_o`=0, `reconfig_done_o`=0;
  - `degraded_o`=0, `fatal_o`=0;
  - FSM in IDLE.
- Fault sampled at edge t → `clock_en_o[3]`=1 and `reconfig_busy_o`=1 from t+1.
- Commit happens at the first edge ≥ t+1+`SETTLE_CYCLES` where `ex_ready_i`=1. Minimum latency is `SETTLE_CYCLES`+1 cycles.
- `sel_mux_o` and the `clock_en_o[j]` clear change on the same edge, which is the commit edge. There is never a cycle where the voter selects an unclocked ALU.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-swap: immediate return to reset values, and the swap is abandoned.

## Configuration
- `CV32E40P_FT_SPARE_WARMUP_EN` defined: WARMUP state and counter present, behaving as described above.
- Not defined: IDLE goes straight to WAIT_IDLE, and `clock_en_o[3]` rises on the commit edge together with the mux change. `SETTLE_CYCLES` is ignored, and minimum latency is 1 cycle.

## Test plan
- Reset, then idle: check `sel_mux_o`=111, `clock_en_o`=0111, and all flags 0.
- `faulty_i`=0001 with `ex_ready_i`=1 and `SETTLE_CYCLES`=2:
  - `clock_en_o`=1111 at t+1;
  - commit at t+3 gives `sel_mux_o`=110, `clock_en_o`=1110, `retired_o`=0001;
  - `reconfig_done_o` pulses once.
- Same fault with `ex_ready_i` held 0 for 10 cycles:
  - busy stays 1 and `sel_mux_o` stays 111;
  - commit happens on the first `ex_ready_i`=1 edge.
- `faulty_i`=1000 at idle: `retired_o`=1000 with no swap. Then `faulty_i`=1010 gives `degraded_o`=1 with `sel_mux_o` unchanged.
- `faulty_i`=0011 simultaneously: swap ALU0 (`sel_mux_o`=110), then `degraded_o`=1. Adding ALU2 (`faulty_i`=0111) gives `fatal_o`=1.
- Assert `rst_n`=0 during WAIT_IDLE: outputs return to reset values asynchronously. The macro-undefined build is checked for 1-cycle commit latency.
